// File: rtl/mips_core.sv
// Single-cycle MIPS-I subset core: fetch, decode, execute, memory and writeback all complete in one clock.
// Instruction memory, data memory and register file live inside the core and are preloaded by hierarchical writes.
module mips_imem #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);
  logic [31:0] regData [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) regData[i_waddr] <= i_wdata;
  end

  assign o_rdata = regData[i_raddr];
endmodule

module mips_dmem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] data_mem_ff [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) data_mem_ff[i_addr] <= i_wdata;
  end

  assign o_rdata = data_mem_ff[i_addr];
endmodule

module mips_regbank (
  input  logic        clk,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b
);
  logic [31:0] reg_file_ff [0:31];

  // $0 is hardwired: writes are dropped and reads return zero regardless of array contents.
  always_ff @(posedge clk) begin
    if (i_we && (i_waddr != 5'd0)) reg_file_ff[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : reg_file_ff[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : reg_file_ff[i_raddr_b];
endmodule

module mips_core #(
  parameter int          DATA_MEM_DEPTH = 256,
  parameter int          IMEM_DEPTH     = 512,
  parameter logic [31:0] TEXT_BASE      = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE      = 32'h1001_0000
) (
  input  logic clk,
  input  logic rst
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DATA_MEM_DEPTH);

  logic [31:0] r_pc, r_hi, r_lo;
  logic [31:0] w_instr, w_pc_plus4, w_pc_off, w_next_pc;
  logic [31:0] w_rs_data, w_rt_data, w_simm, w_zimm, w_mem_addr, w_dmem_off, w_dmem_rdata;
  logic [31:0] w_branch_target, w_jump_target, w_wb_data;
  logic [63:0] w_product;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_wb_addr;
  logic        w_wb_en, w_mem_we, w_hilo_we;
  logic        w_unused;

  assign w_op     = w_instr[31:26];
  assign w_rs     = w_instr[25:21];
  assign w_rt     = w_instr[20:16];
  assign w_rd     = w_instr[15:11];
  assign w_shamt  = w_instr[10:6];
  assign w_funct  = w_instr[5:0];
  assign w_simm   = {{16{w_instr[15]}}, w_instr[15:0]};
  assign w_zimm   = {16'd0, w_instr[15:0]};

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_pc_off        = r_pc - TEXT_BASE;
  assign w_branch_target = w_pc_plus4 + {w_simm[29:0], 2'b00};
  assign w_jump_target   = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
  assign w_mem_addr      = w_rs_data + w_simm;
  assign w_dmem_off      = w_mem_addr - DATA_BASE;
  assign w_product       = $signed(w_rs_data) * $signed(w_rt_data);
  assign w_unused        = ^{w_pc_off[31:IAW+2], w_pc_off[1:0], w_dmem_off[31:DAW+2], w_dmem_off[1:0]};

  // Write port is tied off; contents come only from hierarchical preload.
  mips_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) InstructionMemory (
    .clk(clk), .i_we(1'b0), .i_waddr('0), .i_wdata(32'd0),
    .i_raddr(w_pc_off[IAW+1:2]), .o_rdata(w_instr)
  );

  mips_dmem #(.DEPTH(DATA_MEM_DEPTH), .AW(DAW)) DataMemory (
    .clk(clk), .i_we(w_mem_we & ~rst), .i_addr(w_dmem_off[DAW+1:2]),
    .i_wdata(w_rt_data), .o_rdata(w_dmem_rdata)
  );

  mips_regbank RegBank (
    .clk(clk), .i_we(w_wb_en & ~rst), .i_waddr(w_wb_addr), .i_wdata(w_wb_data),
    .i_raddr_a(w_rs), .i_raddr_b(w_rt), .o_rdata_a(w_rs_data), .o_rdata_b(w_rt_data)
  );

  always_comb begin
    w_wb_en   = 1'b0;
    w_wb_addr = w_rt;
    w_wb_data = 32'd0;
    w_mem_we  = 1'b0;
    w_hilo_we = 1'b0;
    w_next_pc = w_pc_plus4;
    case (w_op)
      6'h00: begin
        w_wb_addr = w_rd;
        w_wb_en   = 1'b1;
        case (w_funct)
          6'h20, 6'h21: w_wb_data = w_rs_data + w_rt_data;
          6'h22, 6'h23: w_wb_data = w_rs_data - w_rt_data;
          6'h24: w_wb_data = w_rs_data & w_rt_data;
          6'h25: w_wb_data = w_rs_data | w_rt_data;
          6'h26: w_wb_data = w_rs_data ^ w_rt_data;
          6'h27: w_wb_data = ~(w_rs_data | w_rt_data);
          6'h2a: w_wb_data = {31'd0, $signed(w_rs_data) < $signed(w_rt_data)};
          6'h2b: w_wb_data = {31'd0, w_rs_data < w_rt_data};
          6'h00: w_wb_data = w_rt_data << w_shamt;
          6'h02: w_wb_data = w_rt_data >> w_shamt;
          6'h03: w_wb_data = $signed(w_rt_data) >>> w_shamt;
          6'h10: w_wb_data = r_hi;
          6'h12: w_wb_data = r_lo;
          6'h08: begin
            w_wb_en   = 1'b0;
            w_next_pc = w_rs_data;
          end
          6'h18: begin
            w_wb_en   = 1'b0;
            w_hilo_we = 1'b1;
          end
          default: w_wb_en = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin w_wb_en = 1'b1; w_wb_data = w_rs_data + w_simm; end
      6'h0a: begin w_wb_en = 1'b1; w_wb_data = {31'd0, $signed(w_rs_data) < $signed(w_simm)}; end
      6'h0c: begin w_wb_en = 1'b1; w_wb_data = w_rs_data & w_zimm; end
      6'h0d: begin w_wb_en = 1'b1; w_wb_data = w_rs_data | w_zimm; end
      6'h0e: begin w_wb_en = 1'b1; w_wb_data = w_rs_data ^ w_zimm; end
      6'h0f: begin w_wb_en = 1'b1; w_wb_data = {w_instr[15:0], 16'd0}; end
      6'h23: begin w_wb_en = 1'b1; w_wb_data = w_dmem_rdata; end
      6'h2b: w_mem_we = 1'b1;
      6'h04: if (w_rs_data == w_rt_data) w_next_pc = w_branch_target;
      6'h05: if (w_rs_data != w_rt_data) w_next_pc = w_branch_target;
      6'h02: w_next_pc = w_jump_target;
      6'h03: begin
        w_next_pc = w_jump_target;
        w_wb_en   = 1'b1;
        w_wb_addr = 5'd31;
        w_wb_data = w_pc_plus4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= TEXT_BASE;
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      r_pc <= w_next_pc;
      if (w_hilo_we) begin
        r_hi <= w_product[63:32];
        r_lo <= w_product[31:0];
      end
    end
  end
endmodule

// File: tb/tb_mips_core.sv
// Directed bench for mips_core: programs are preloaded through the internal arrays while reset is held,
// then architectural state is compared against hand-computed values.
module tb_mips_core;
  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  mips_core dut (
    .clk(clk),
    .rst(rst)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then park on the falling edge for driving and sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_all();
    for (int i = 0; i < 512; i++) dut.InstructionMemory.regData[i] = 32'h0000_0000;
    for (int i = 0; i < 256; i++) dut.DataMemory.data_mem_ff[i] = 32'h0000_0000;
    for (int i = 0; i < 32; i++) dut.RegBank.reg_file_ff[i] = 32'h0000_0000;
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    step(2);

    // ---- immediates, multiply, mid-run reset ----
    clear_all();
    dut.InstructionMemory.regData[0] = 32'h2006_0007;  // addi $6,$0,7
    dut.InstructionMemory.regData[1] = 32'h2001_000f;
    dut.InstructionMemory.regData[2] = 32'h2002_0002;
    dut.InstructionMemory.regData[3] = 32'h2003_00ff;
    dut.InstructionMemory.regData[4] = 32'h0022_0018;  // mult $1,$2
    dut.InstructionMemory.regData[5] = 32'h0000_2012;  // mflo $4
    dut.InstructionMemory.regData[6] = 32'h0061_0018;  // mult $3,$1
    dut.InstructionMemory.regData[7] = 32'h0000_2810;  // mfhi $5
    dut.RegBank.reg_file_ff[5]       = 32'hdead_beef;
    dut.DataMemory.data_mem_ff[0]    = 32'hcafe_f00d;
    step(2);
    check_eq("rst_pc", dut.r_pc, 32'h0040_0000);
    check_eq("rst_hi", dut.r_hi, 32'h0);
    check_eq("rst_lo", dut.r_lo, 32'h0);
    check_eq("rst_no_wb", dut.RegBank.reg_file_ff[6], 32'h0);
    rst = 1'b0;
    step(4);
    check_eq("imm_r1", dut.RegBank.reg_file_ff[1], 32'd15);
    check_eq("imm_r2", dut.RegBank.reg_file_ff[2], 32'd2);
    check_eq("imm_r3", dut.RegBank.reg_file_ff[3], 32'd255);
    check_eq("imm_r6", dut.RegBank.reg_file_ff[6], 32'd7);
    check_eq("imm_pc", dut.r_pc, 32'h0040_0010);
    step(2);
    check_eq("mult1_lo", dut.r_lo, 32'd30);
    check_eq("mult1_hi", dut.r_hi, 32'd0);
    check_eq("mflo_r4", dut.RegBank.reg_file_ff[4], 32'd30);
    step(2);
    check_eq("mult2_lo", dut.r_lo, 32'd3825);
    check_eq("mfhi_r5", dut.RegBank.reg_file_ff[5], 32'd0);
    rst = 1'b1;
    step(2);
    check_eq("midrst_pc", dut.r_pc, 32'h0040_0000);
    check_eq("midrst_lo", dut.r_lo, 32'd0);
    check_eq("midrst_r3", dut.RegBank.reg_file_ff[3], 32'd255);
    check_eq("midrst_r4", dut.RegBank.reg_file_ff[4], 32'd30);
    check_eq("midrst_dmem", dut.DataMemory.data_mem_ff[0], 32'hcafe_f00d);
    rst = 1'b0;
    step(1);
    check_eq("midrst_restart", dut.r_pc, 32'h0040_0004);

    // ---- lowest value search ----
    rst = 1'b1;
    step(2);
    clear_all();
    dut.RegBank.reg_file_ff[1] = 32'h1001_0000;
    for (int i = 0; i < 10; i++) dut.DataMemory.data_mem_ff[i] = 32'(10 - i);
    dut.DataMemory.data_mem_ff[10]   = 32'hffff_ffff;
    dut.InstructionMemory.regData[1]  = 32'h2022_0024;
    dut.InstructionMemory.regData[2]  = 32'h8c23_0000;
    dut.InstructionMemory.regData[3]  = 32'h2021_0004;
    dut.InstructionMemory.regData[4]  = 32'h8c24_0000;
    dut.InstructionMemory.regData[5]  = 32'h0083_282a;
    dut.InstructionMemory.regData[6]  = 32'h10a0_0001;
    dut.InstructionMemory.regData[7]  = 32'h0080_1820;
    dut.InstructionMemory.regData[8]  = 32'h1022_0001;
    dut.InstructionMemory.regData[9]  = 32'h0810_0003;
    dut.InstructionMemory.regData[10] = 32'hac23_0004;
    dut.InstructionMemory.regData[11] = 32'h2000_0000;
    dut.InstructionMemory.regData[12] = 32'h0810_000b;
    step(1);
    rst = 1'b0;
    cyc = 0;
    while (dut.r_pc != 32'h0040_0030 && cyc < 500) begin
      step(1);
      cyc++;
    end
    check_eq("low_reach_pc", dut.r_pc, 32'h0040_0030);
    check_eq("low_result", dut.DataMemory.data_mem_ff[10], 32'd1);
    check_eq("low_r3", dut.RegBank.reg_file_ff[3], 32'd1);
    step(1);
    check_eq("low_loop_a", dut.r_pc, 32'h0040_002c);
    step(1);
    check_eq("low_loop_b", dut.r_pc, 32'h0040_0030);

    // ---- store under reset, overflow, $0, branches, jumps ----
    rst = 1'b1;
    step(2);
    clear_all();
    dut.RegBank.reg_file_ff[16] = 32'h1001_0000;
    dut.RegBank.reg_file_ff[10] = 32'h1234_5678;
    dut.InstructionMemory.regData[0]  = 32'hae10_0008;  // sw $16,8($16)
    dut.InstructionMemory.regData[1]  = 32'h3c07_7fff;  // lui $7,0x7fff
    dut.InstructionMemory.regData[2]  = 32'h34e7_ffff;  // ori $7,$7,0xffff
    dut.InstructionMemory.regData[3]  = 32'h2008_0001;  // addi $8,$0,1
    dut.InstructionMemory.regData[4]  = 32'h00e8_4820;  // add $9,$7,$8
    dut.InstructionMemory.regData[5]  = 32'h2000_0001;  // addi $0,$0,1
    dut.InstructionMemory.regData[6]  = 32'h1508_0003;  // bne $8,$8,+3
    dut.InstructionMemory.regData[7]  = 32'h0810_0023;  // j index 35
    dut.InstructionMemory.regData[35] = 32'h1000_0005;  // beq $0,$0,+5
    dut.InstructionMemory.regData[36] = 32'h200a_0055;  // addi $10 (skipped)
    dut.InstructionMemory.regData[41] = 32'h0c10_0032;  // jal index 50
    dut.InstructionMemory.regData[42] = 32'h0810_0029;  // j index 41
    dut.InstructionMemory.regData[50] = 32'h0008_6100;  // sll $12,$8,4
    dut.InstructionMemory.regData[51] = 32'h0009_6903;  // sra $13,$9,4
    dut.InstructionMemory.regData[52] = 32'h0109_702b;  // sltu $14,$8,$9
    dut.InstructionMemory.regData[53] = 32'h0128_782a;  // slt $15,$9,$8
    dut.InstructionMemory.regData[54] = 32'h03e0_0008;  // jr $31
    step(2);
    check_eq("rst_no_store", dut.DataMemory.data_mem_ff[2], 32'h0);
    rst = 1'b0;
    step(1);
    check_eq("sw_store", dut.DataMemory.data_mem_ff[2], 32'h1001_0000);
    step(4);
    check_eq("ovf_r7", dut.RegBank.reg_file_ff[7], 32'h7fff_ffff);
    check_eq("ovf_add", dut.RegBank.reg_file_ff[9], 32'h8000_0000);
    check_eq("ovf_pc", dut.r_pc, 32'h0040_0014);
    step(1);
    check_eq("r0_zero", dut.RegBank.reg_file_ff[0], 32'h0);
    step(1);
    check_eq("bne_fall", dut.r_pc, 32'h0040_001c);
    step(1);
    check_eq("j_pc", dut.r_pc, 32'h0040_008c);
    step(1);
    check_eq("beq_pc", dut.r_pc, 32'h0040_00a4);
    check_eq("beq_skip", dut.RegBank.reg_file_ff[10], 32'h1234_5678);
    step(1);
    check_eq("jal_pc", dut.r_pc, 32'h0040_00c8);
    check_eq("jal_r31", dut.RegBank.reg_file_ff[31], 32'h0040_00a8);
    step(3);
    check_eq("sll_r12", dut.RegBank.reg_file_ff[12], 32'd16);
    check_eq("sra_r13", dut.RegBank.reg_file_ff[13], 32'hf800_0000);
    check_eq("sltu_r14", dut.RegBank.reg_file_ff[14], 32'd1);
    step(1);
    check_eq("slt_r15", dut.RegBank.reg_file_ff[15], 32'd1);
    step(1);
    check_eq("jr_pc", dut.r_pc, 32'h0040_00a8);
    step(1);
    check_eq("j29_pc", dut.r_pc, 32'h0040_00a4);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
